operand_collector: RTL and testbench
====================================

OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 4, width in bits of each operand word.
REQ-002 SHALL have parameter NB_INS, default 3, number of operand words per set; legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous flush of the partially or fully collected set.
REQ-006 SHALL have port in_valid  input  1  upstream word available on in_bus.
REQ-007 SHALL have port in_ready  output  1  collector accepts in_bus this cycle.
REQ-008 SHALL have port in_bus  input  BUS_WIDTH  operand word.
REQ-009 SHALL have port out_valid  output  1  a complete set of NB_INS words is presented.
REQ-010 SHALL have port out_ready  input  1  downstream reduction stage consumes the set.
REQ-011 SHALL have port out_buses  output  NB_INS*BUS_WIDTH  flattened set; slot i at bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-012 SHALL have port count  output  $clog2(NB_INS+1)  number of slots currently filled.

Function
REQ-013 SHALL implement two states: FILL (collecting) and HOLD (set complete, awaiting consumer).
REQ-014 In FILL, in_ready SHALL be 1 and out_valid 0; an accept (in_valid & in_ready) writes in_bus into slot count and increments count.
REQ-015 An accept when count == NB_INS-1 SHALL move to HOLD; out_valid rises the next cycle with count == NB_INS (one-cycle latency from last accept).
REQ-016 In HOLD, out_buses and count SHALL be stable; in_ready SHALL be 0 (except per REQ-024).
REQ-017 In HOLD, out_valid & out_ready SHALL return to FILL with count = 0; slot contents are retained but no longer valid.
REQ-018 clear SHALL override all other inputs: next state FILL, count 0, all slots zeroed, any simultaneous accept or consume discarded.
REQ-019 in_valid while in_ready is 0 SHALL have no effect; in_bus is not sampled.
REQ-020 out_ready while out_valid is 0 SHALL have no effect.
REQ-021 count SHALL never exceed NB_INS and never wrap.

Reset
REQ-022 On rst_n low, asynchronously: state FILL, count 0, all slots 0, out_valid 0; in_ready 1 after rst_n deasserts.
REQ-023 rst_n asserted mid-set SHALL discard the partial set; first accept after reset lands in slot 0.

Configuration
REQ-024 With OPERAND_COLLECTOR_OVERLAP_EN defined, in HOLD in_ready SHALL equal out_ready; a same-cycle consume and accept moves to FILL with the new word in slot 0 and count 1 (zero-bubble streaming).
REQ-025 Without OPERAND_COLLECTOR_OVERLAP_EN, in_ready SHALL be 0 throughout HOLD, giving one bubble cycle between sets.

Structure
REQ-026 State encodings (FILL=0, HOLD=1) SHALL live in the shared boolean package header, alongside other boolean-unit constants.
REQ-027 Each slot SHALL be an instance of sub-module bus_reg (BUS_WIDTH-bit enable-load register, async active-low reset, sync clear).
REQ-028 Control logic (state, count, handshakes) SHALL be in operand_collector itself.

Verification (BUS_WIDTH=4, NB_INS=3)
REQ-029 Accept 1101, 1011, 1111 on consecutive cycles -> out_valid=1 next cycle, out_buses=12'hFBD, count=3, in_ready=0.
REQ-030 Hold out_ready=0 for 5 cycles in HOLD while toggling in_valid/in_bus -> out_buses stays 12'hFBD, count stays 3.
REQ-031 Assert clear after two accepts (count=2) -> next cycle count=0, out_buses=12'h000, next accept goes to slot 0.
REQ-032 Pulse rst_n low mid-set (count=1) between clock edges -> count=0 and out_valid=0 immediately, before next edge.
REQ-033 Back-to-back sets with out_ready=1 and in_valid=1 continuously -> with OVERLAP_EN, one set every 3 cycles; without, one set every 4 cycles.
REQ-034 Assert clear and out_ready together in HOLD -> FILL, count 0, slots zeroed, no new word accepted that cycle.

Source files
------------

// File: rtl/operand_collector_pkg.sv
// Shared constants for the operand collector.
// Holds the FILL/HOLD state encoding.
package operand_collector_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } oc_state_e;

endpackage

// File: rtl/operand_collector_bus_reg.sv
// One operand slot: enable-load register.
// Async active-low reset, sync clear (clear wins).
module bus_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable; clear zeroes the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/operand_collector.sv
// Collects NB_INS operand words into one set.
// Optional OPERAND_COLLECTOR_OVERLAP_EN: accept in HOLD.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int BUS_WIDTH = 4,
  parameter int NB_INS    = 3,
  localparam int CW       = $clog2(NB_INS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BUS_WIDTH-1:0]        in_bus,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NB_INS*BUS_WIDTH-1:0] out_buses,
  output logic [CW-1:0]               count
);

  oc_state_e   state, state_nxt;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] wr_idx;
  logic [NB_INS-1:0] wr_en;
  logic        accept, consume;

  assign accept  = in_valid & in_ready & ~clear;
  assign consume = out_valid & out_ready & ~clear;

  // State and fill count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next state and next count
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (clear) begin
      state_nxt = FILL;
      count_nxt = '0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            count_nxt = CW'(count + 1'b1);
            if (count == CW'(NB_INS - 1))
              state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            state_nxt = FILL;
            count_nxt = accept ? CW'(1) : '0;
          end
        end
        default: begin
          state_nxt = FILL;
          count_nxt = '0;
        end
      endcase
    end
  end

  // Handshake outputs and slot write enables
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_idx    = count;
    wr_en     = '0;
    unique case (state)
      FILL: in_ready = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        wr_idx    = '0;
`ifdef OPERAND_COLLECTOR_OVERLAP_EN
        in_ready  = out_ready;
`else
        in_ready  = 1'b0;
`endif
      end
      default: in_ready = 1'b0;
    endcase
    for (int i = 0; i < NB_INS; i++)
      wr_en[i] = accept && (wr_idx == CW'(i));
  end

  for (genvar i = 0; i < NB_INS; i++) begin : g_slot
    bus_reg #(.W(BUS_WIDTH)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(clear),
      .en   (wr_en[i]),
      .d    (in_bus),
      .q    (out_buses[i*BUS_WIDTH +: BUS_WIDTH])
    );
  end

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector.
// BUS_WIDTH=4, NB_INS=3.
module tb_operand_collector;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_bus;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_buses;
  logic [1:0]  count;

  int pass_cnt;
  int total_cnt;

  operand_collector #(.BUS_WIDTH(4), .NB_INS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bus   (in_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_buses(out_buses),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cons_cyc[$];
    logic [11:0] cons_bus[$];
    int gap_exp;
    logic [11:0] set2_exp;

    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_bus    = 4'h0;
    out_ready = 1'b0;

    #2;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_buses", out_buses, 12'h000);

    step();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    in_valid = 1'b1;
    in_bus = 4'hD; step();
    in_bus = 4'hB; step();
    in_bus = 4'hF; step();
    in_valid = 1'b0;
    check("set_out_valid", out_valid, 1);
    check("set_out_buses", out_buses, 12'hFBD);
    check("set_count", count, 3);
    check("set_in_ready", in_ready, 0);

    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_bus   = 4'(k * 3 + 1);
      step();
      check("hold_buses", out_buses, 12'hFBD);
      check("hold_count", count, 3);
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("consume_valid", out_valid, 0);
    check("consume_count", count, 0);
    check("consume_retain", out_buses, 12'hFBD);

    in_valid = 1'b1;
    in_bus = 4'h3; step();
    in_bus = 4'h5; step();
    check("two_count", count, 2);
    check("two_buses", out_buses, 12'hF53);
    clear  = 1'b1;
    in_bus = 4'h7;
    step();
    clear = 1'b0;
    check("clear_count", count, 0);
    check("clear_buses", out_buses, 12'h000);
    in_bus = 4'h9;
    step();
    in_valid = 1'b0;
    check("post_clear_count", count, 1);
    check("post_clear_slot0", out_buses, 12'h009);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_valid", out_valid, 0);
    check("async_buses", out_buses, 12'h000);
    #1;
    rst_n = 1'b1;
    step();
    in_valid = 1'b1;
    in_bus = 4'hA; step();
    check("post_rst_count", count, 1);
    check("post_rst_slot0", out_buses, 12'h00A);
    in_bus = 4'h1; step();
    in_bus = 4'h2; step();
    check("hold2_valid", out_valid, 1);
    check("hold2_buses", out_buses, 12'h21A);

    clear     = 1'b1;
    out_ready = 1'b1;
    in_bus    = 4'hE;
    step();
    clear = 1'b0;
    check("clr_cons_valid", out_valid, 0);
    check("clr_cons_count", count, 0);
    check("clr_cons_buses", out_buses, 12'h000);

    for (int c = 0; c < 20; c++) begin
      in_bus = 4'(c);
      #1;
      if (out_valid) begin
        cons_cyc.push_back(c);
        cons_bus.push_back(out_buses);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

`ifdef OPERAND_COLLECTOR_OVERLAP_EN
    gap_exp  = 3;
    set2_exp = 12'h543;
`else
    gap_exp  = 4;
    set2_exp = 12'h654;
`endif
    check("stream_nsets_ge3", 32'(cons_cyc.size() >= 3), 1);
    if (cons_cyc.size() >= 3) begin
      check("stream_first", cons_cyc[0], 3);
      check("stream_gap1", cons_cyc[1] - cons_cyc[0], gap_exp);
      check("stream_gap2", cons_cyc[2] - cons_cyc[1], gap_exp);
      check("stream_set1", cons_bus[0], 12'h210);
      check("stream_set2", cons_bus[1], set2_exp);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
